// File: rtl/heartbeat_pkg.sv
// Shared mode encoding for the multi-channel heartbeat.
package heartbeat_pkg;

    localparam int unsigned HB_MODE_W = 2;

    typedef enum logic [HB_MODE_W-1:0] {
        HB_OFF    = 2'd0,
        HB_TOGGLE = 2'd1,
        HB_PULSE  = 2'd2,
        HB_PWM    = 2'd3
    } hb_mode_t;

endpackage

// File: rtl/heartbeat_channel.sv
// One heartbeat channel: programmable-period counter with shadowed config
// that reloads only at the wrap, driving a registered out/tick pair.
module heartbeat_channel
    import heartbeat_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [HB_MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]     period,
    input  logic [WIDTH-1:0]     duty,
    output logic                 out,
    output logic                 tick
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] prd_q;
    logic [WIDTH-1:0] duty_q;
    hb_mode_t         mode_q;

    logic             wrap;
    logic [WIDTH-1:0] cnt_next;
    logic             out_next;

    always_comb begin
        wrap     = (cnt == prd_q);
        cnt_next = wrap ? '0 : cnt + WIDTH'(1);
        out_next = 1'b0;
        case (mode_q)
            HB_OFF:    out_next = 1'b0;
            HB_TOGGLE: out_next = wrap ? ~out : out;
            HB_PULSE:  out_next = wrap;
            // Compare against the next count so the high phase lines up with cnt 0..D-1.
            HB_PWM:    out_next = (cnt_next < duty_q);
            default:   out_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            out    <= 1'b0;
            tick   <= 1'b0;
            prd_q  <= '0;
            duty_q <= '0;
            mode_q <= HB_OFF;
        end else if (!en) begin
            cnt    <= '0;
            out    <= 1'b0;
            tick   <= 1'b0;
            prd_q  <= period;
            duty_q <= duty;
            mode_q <= hb_mode_t'(mode);
        end else begin
            cnt  <= cnt_next;
            tick <= wrap;
            out  <= out_next;
            if (wrap) begin
                prd_q  <= period;
                duty_q <= duty;
                mode_q <= hb_mode_t'(mode);
            end
        end
    end

endmodule

// File: rtl/heartbeat_multi.sv
// Multi-channel heartbeat: slices the packed config buses into independent
// heartbeat_channel instances.
module heartbeat_multi
    import heartbeat_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           en,
    input  logic [HB_MODE_W*CHANNELS-1:0] mode,
    input  logic [WIDTH*CHANNELS-1:0]     period,
    input  logic [WIDTH*CHANNELS-1:0]     duty,
    output logic [CHANNELS-1:0]           out,
    output logic [CHANNELS-1:0]           tick
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        heartbeat_channel #(
            .WIDTH(WIDTH)
        ) u_channel (
            .clk   (clk),
            .reset (reset),
            .en    (en[g]),
            .mode  (mode[HB_MODE_W*g +: HB_MODE_W]),
            .period(period[WIDTH*g +: WIDTH]),
            .duty  (duty[WIDTH*g +: WIDTH]),
            .out   (out[g]),
            .tick  (tick[g])
        );
    end

endmodule

// File: tb/tb_heartbeat_multi.sv
// Bench for heartbeat_multi: directed scenarios with literal expectations plus
// randomized traffic, all outputs checked every cycle against a channel model.
module tb_heartbeat_multi;

    localparam int CH = 4;
    localparam int W  = 8;

    logic            clk;
    logic            reset;
    logic [CH-1:0]   en;
    logic [2*CH-1:0] mode;
    logic [W*CH-1:0] period;
    logic [W*CH-1:0] duty;
    logic [CH-1:0]   out;
    logic [CH-1:0]   tick;

    int vectors     = 0;
    int miscompares = 0;

    heartbeat_multi #(
        .WIDTH   (W),
        .CHANNELS(CH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .period(period),
        .duty  (duty),
        .out   (out),
        .tick  (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-channel phase and active configuration as plain ints.
    int m_phase [CH];
    int m_prd   [CH];
    int m_duty  [CH];
    int m_mode  [CH];
    bit m_out   [CH];
    bit m_tick  [CH];
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (reset) begin
                m_phase[i] = 0; m_prd[i] = 0; m_duty[i] = 0; m_mode[i] = 0;
                m_out[i] = 1'b0; m_tick[i] = 1'b0;
            end else if (!en[i]) begin
                m_phase[i] = 0; m_out[i] = 1'b0; m_tick[i] = 1'b0;
                m_prd[i]  = int'(period[W*i +: W]);
                m_duty[i] = int'(duty[W*i +: W]);
                m_mode[i] = int'(mode[2*i +: 2]);
            end else begin
                bit last;
                int nxt;
                last = (m_phase[i] == m_prd[i]);
                nxt  = last ? 0 : m_phase[i] + 1;
                case (m_mode[i])
                    1:       if (last) m_out[i] = !m_out[i];
                    2:       m_out[i] = last;
                    3:       m_out[i] = (nxt < m_duty[i]);
                    default: m_out[i] = 1'b0;
                endcase
                m_tick[i]  = last;
                m_phase[i] = nxt;
                if (last) begin
                    m_prd[i]  = int'(period[W*i +: W]);
                    m_duty[i] = int'(duty[W*i +: W]);
                    m_mode[i] = int'(mode[2*i +: 2]);
                end
            end
        end
        if (reset) model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < CH; i++) begin
                vectors++;
                if (out[i] !== m_out[i]) begin
                    miscompares++;
                    $display("FAIL out[%0d] @%0t: got %b, expected %b", i, $time, out[i], m_out[i]);
                end
                vectors++;
                if (tick[i] !== m_tick[i]) begin
                    miscompares++;
                    $display("FAIL tick[%0d] @%0t: got %b, expected %b", i, $time, tick[i], m_tick[i]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg(input int ch, input int md, input int p, input int d);
        mode[2*ch +: 2]   = 2'(md);
        period[W*ch +: W] = W'(p);
        duty[W*ch +: W]   = W'(d);
    endtask

    // Steps up to limit edges, recording the first three tick edges and first out rise/fall.
    task automatic observe(input int ch, input int limit, input int chg_at, input int chg_p,
                           output int t1, output int t2, output int t3,
                           output int rise, output int fall);
        int  nt;
        logic prev;
        t1 = -1; t2 = -1; t3 = -1; rise = -1; fall = -1; nt = 0;
        prev = out[ch];
        for (int k = 1; k <= limit; k++) begin
            step();
            if (tick[ch] === 1'b1) begin
                if (nt == 0) t1 = k; else if (nt == 1) t2 = k; else if (nt == 2) t3 = k;
                nt++;
            end
            if (prev !== 1'b1 && out[ch] === 1'b1 && rise < 0) rise = k;
            if (prev === 1'b1 && out[ch] !== 1'b1 && fall < 0) fall = k;
            prev = out[ch];
            if (k == chg_at) period[W*ch +: W] = W'(chg_p);
        end
    endtask

    task automatic count_high(input int ch, input int n, output int o_cnt, output int t_cnt);
        o_cnt = 0; t_cnt = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (out[ch] === 1'b1) o_cnt++;
            if (tick[ch] === 1'b1) t_cnt++;
        end
    endtask

    int t1, t2, t3, rise, fall, oc, tc, tc0;

    initial begin
        reset = 1'b1; en = '0; mode = '0; period = '0; duty = '0;
        step(); step();
        chk("reset_out", int'(out), 0);
        chk("reset_tick", int'(tick), 0);
        reset = 1'b0;

        // Legacy heartbeat: TOGGLE, P=127.
        cfg(0, 1, 127, 0); step(); en[0] = 1'b1;
        observe(0, 400, -1, 0, t1, t2, t3, rise, fall);
        chk("legacy_tick1", t1, 128);
        chk("legacy_tick2", t2, 256);
        chk("legacy_tick3", t3, 384);
        chk("legacy_rise", rise, 128);
        chk("legacy_fall", fall, 256);
        en = '0; step();

        // PWM duty sweep on channel 3.
        cfg(3, 3, 9, 3); step(); en[3] = 1'b1;
        repeat (20) step();
        count_high(3, 10, oc, tc);
        chk("pwm_d3_high", oc, 3);
        duty[W*3 +: W] = W'(0); repeat (12) step();
        count_high(3, 100, oc, tc);
        chk("pwm_d0_high", oc, 0);
        duty[W*3 +: W] = W'(10); repeat (12) step();
        count_high(3, 100, oc, tc);
        chk("pwm_d10_high", oc, 100);
        en = '0; step();

        // Period change mid-period takes effect only after the current wrap.
        cfg(0, 1, 9, 0); step(); en[0] = 1'b1;
        observe(0, 22, 5, 4, t1, t2, t3, rise, fall);
        chk("shadow_tick1", t1, 10);
        chk("shadow_tick2", t2, 15);
        chk("shadow_tick3", t3, 20);
        chk("shadow_rise", rise, 10);
        en = '0; step();

        // P=0 pulse: high every enabled cycle.
        cfg(1, 2, 0, 0); step(); en[1] = 1'b1;
        count_high(1, 20, oc, tc);
        chk("p0_out", oc, 20);
        chk("p0_tick", tc, 20);
        en = '0; step();

        // Maximum period wraps cleanly.
        cfg(2, 2, 255, 0); step(); en[2] = 1'b1;
        observe(2, 300, -1, 0, t1, t2, t3, rise, fall);
        chk("pmax_tick1", t1, 256);
        chk("pmax_tick2", t2, -1);
        en = '0; step();

        // Abort by enable drop and by reset, then re-enable.
        cfg(1, 1, 9, 0); cfg(2, 1, 9, 0); step();
        en[1] = 1'b1; en[2] = 1'b1;
        repeat (6) step();
        en[1] = 1'b0; step();
        chk("abort_en_out", int'(out[1]), 0);
        chk("abort_en_tick", int'(tick[1]), 0);
        repeat (2) step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("abort_rst_out", int'(out), 0);
        chk("abort_rst_tick", int'(tick), 0);
        step();
        en[1] = 1'b1; en[2] = 1'b0;
        observe(1, 15, -1, 0, t1, t2, t3, rise, fall);
        chk("reenable_tick1", t1, 10);
        en = '0; step();

        // Independent channels over 500 cycles.
        cfg(0, 1, 1, 0); cfg(1, 2, 2, 0); cfg(2, 3, 4, 1); cfg(3, 1, 8, 0);
        step(); en = '1;
        tc0 = 0; tc = 0;
        for (int k = 0; k < 500; k++) begin
            step();
            if (tick[0] === 1'b1) tc0++;
            if (tick[3] === 1'b1) tc++;
        end
        chk("indep_ticks_ch0", tc0, 250);
        chk("indep_ticks_ch3", tc, 55);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 31) == 0) en[i] = ~en[i];
                if ($urandom_range(0, 15) == 0) begin
                    int p;
                    p = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                                    : int'($urandom_range(0, 15));
                    cfg(i, int'($urandom_range(0, 3)), p, int'($urandom_range(0, 17)));
                end
            end
            step();
        end
        reset = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
